// File: rtl/axi_lite_wr_master_pkg.sv
// rtl/axi_lite_wr_master_pkg.sv - shared constants and types for the AXI-lite write master
//
// Purpose: BRESP codes, FSM state encoding and a strobe-mask helper used by
// axi_lite_wr_master. No ports.

package axi_lite_wr_master_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR_DATA = 3'd1,
    ST_WAIT_B    = 3'd2,
    ST_RESP      = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  // One bit per byte lane that exists on the data bus; lanes beyond it are 0.
  function automatic logic [63:0] strb_mask(input int bytes);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < bytes) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_wr_timer.sv
// rtl/axi_wr_timer.sv - clear/enable cycle counter flagging when TIMEOUT-1 is reached
//
// Purpose: counts cycles while enabled; expired goes high when the count
// equals TIMEOUT-1 and the counter then holds, so it never wraps.
// Ports:
//   aclock   in  clock
//   areset   in  synchronous active-high reset
//   clear    in  force count to 0 (takes priority over enable)
//   enable   in  count one per cycle
//   expired  out count == TIMEOUT-1

module axi_wr_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic aclock,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge aclock) begin
    if (areset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/axi_lite_wr_master.sv
// rtl/axi_lite_wr_master.sv - single-outstanding AXI-lite write master for LSU stores
//
// Purpose: accepts one store request, issues AW and W independently, waits
// for B (or times out) and hands the completion back to the LSU.
// Ports:
//   aclock, areset                      clock, synchronous active-high reset
//   req_valid/req_ready/req_addr/req_data/req_strb   LSU store request
//   resp_valid/resp_ready/resp_err/resp_code/resp_timeout   completion to LSU
//   awaddr/awvalid/awready              AXI write address channel
//   wdata/wstrb/wvalid/wready           AXI write data channel
//   bvalid/bready/bresp                 AXI write response channel
// All outputs are registered except req_ready.

module axi_lite_wr_master
  import axi_lite_wr_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              aclock,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [STRB_W-1:0] req_strb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic [1:0]        resp_code,
  output logic              resp_timeout,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);

  localparam logic [63:0]       MASK_ALL  = strb_mask(DATA_W / 8);
  localparam logic [STRB_W-1:0] STRB_MASK = MASK_ALL[STRB_W-1:0];

  state_t state;
  logic   drain_pending;   // set on timeout: a late B may still arrive
  logic   timer_expired;
  logic   aw_done_now;
  logic   w_done_now;

  // A channel counts as done if its valid already dropped or handshakes now.
  assign aw_done_now = !awvalid || awready;
  assign w_done_now  = !wvalid  || wready;

  assign req_ready = (state == ST_IDLE) && !areset;

  axi_wr_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .aclock  (aclock),
    .areset  (areset),
    .clear   (state != ST_WAIT_B),
    .enable  (state == ST_WAIT_B),
    .expired (timer_expired)
  );

  always_ff @(posedge aclock) begin
    if (areset) begin
      state         <= ST_IDLE;
      awvalid       <= 1'b0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_code     <= 2'b00;
      resp_timeout  <= 1'b0;
      drain_pending <= 1'b0;
      awaddr        <= '0;
      wdata         <= '0;
      wstrb         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            awaddr  <= req_addr;
            wdata   <= req_data;
            wstrb   <= req_strb & STRB_MASK;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= ST_ADDR_DATA;
          end
        end
        ST_ADDR_DATA: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_done_now && w_done_now) begin
            bready <= 1'b1;
            state  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (bvalid) begin
            resp_code     <= bresp;
            resp_err      <= (bresp != BRESP_OKAY);
            resp_timeout  <= 1'b0;
            resp_valid    <= 1'b1;
            bready        <= 1'b0;
            drain_pending <= 1'b0;
            state         <= ST_RESP;
          end else if (timer_expired) begin
            resp_code     <= BRESP_DECERR;
            resp_err      <= 1'b1;
            resp_timeout  <= 1'b1;
            resp_valid    <= 1'b1;
            bready        <= 1'b0;
            drain_pending <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (drain_pending) begin
              bready <= 1'b1;
              state  <= ST_DRAIN;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          // Swallow the late B of the timed-out write before taking new work.
          if (bvalid) begin
            bready        <= 1'b0;
            drain_pending <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_master.sv
// tb/tb_axi_lite_wr_master.sv - self-checking bench for axi_lite_wr_master

module tb_axi_lite_wr_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 8;
  localparam int TIMEOUT = 16;

  logic              aclock = 1'b0;
  logic              areset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [STRB_W-1:0] req_strb;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_err;
  logic [1:0]        resp_code;
  logic              resp_timeout;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  int checks = 0;
  int errors = 0;

  always #5 aclock = ~aclock;

  axi_lite_wr_master #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .STRB_W (STRB_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .aclock (aclock), .areset (areset),
    .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
    .req_data (req_data), .req_strb (req_strb),
    .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_err (resp_err),
    .resp_code (resp_code), .resp_timeout (resp_timeout),
    .awaddr (awaddr), .awvalid (awvalid), .awready (awready),
    .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready),
    .bvalid (bvalid), .bready (bready), .bresp (bresp)
  );

  // Reference: only byte lanes present on a DATA_W bus survive.
  function automatic logic [STRB_W-1:0] exp_strb(input logic [STRB_W-1:0] s);
    logic [STRB_W-1:0] r;
    r = '0;
    for (int i = 0; i < STRB_W; i++) if (i < DATA_W / 8) r[i] = s[i];
    return r;
  endfunction

  // Drives one store through the slave model and checks every cycle from
  // request to completion. Delays are in cycles of the valid being visible.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data,
                         input logic [7:0] strb, input int aw_dly, input int w_dly,
                         input int b_dly, input logic [1:0] br, input int rr_dly,
                         input bit do_timeout, input bit do_reset, input bit noise);
    int t, guard, aw_wait, w_wait, b_wait, aw_hi, w_hi, t_bready;
    bit aw_done, w_done, aw_pend, w_pend, b_pend, resp_seen, exp_rv;
    bit exp_err, exp_to;
    logic [1:0] exp_code;
    @(negedge aclock);
    req_valid = 1'b1; req_addr = addr; req_data = data; req_strb = strb;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge aclock);
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    t = 0; aw_wait = 0; w_wait = 0; b_wait = 0; aw_hi = 0; w_hi = 0; t_bready = -1;
    aw_done = 0; w_done = 0; aw_pend = 0; w_pend = 0; b_pend = 0; resp_seen = 0;
    while (!resp_seen && t < 200) begin
      @(negedge aclock);
      t++;
      if (t == 1) begin
        req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_strb = 8'($urandom);
      end
      if (aw_pend) begin aw_done = 1; aw_pend = 0; end
      if (w_pend)  begin w_done = 1;  w_pend = 0;  end
      exp_rv = b_pend || (do_timeout && t_bready >= 0 && (t - t_bready) == TIMEOUT);
      b_pend = 0;
      checks++;
      if (resp_valid !== exp_rv) begin
        errors++;
        $display("FAIL resp_valid_timing: t=%0d resp_valid=%b required %b", t, resp_valid, exp_rv);
      end
      if (resp_valid || exp_rv) begin
        resp_seen = 1;
        bvalid = 1'b0;
        continue;
      end
      // AW channel
      checks++;
      if (!aw_done) begin
        if (awvalid !== 1'b1 || awaddr !== addr) begin
          errors++;
          $display("FAIL aw_hold: t=%0d awvalid=%b awaddr=%h required 1/%h", t, awvalid, awaddr, addr);
        end
        aw_hi++;
        if (aw_wait >= aw_dly) begin awready = 1'b1; aw_pend = 1; end
        else begin awready = 1'b0; aw_wait++; end
      end else begin
        if (awvalid !== 1'b0) begin
          errors++;
          $display("FAIL aw_drop: t=%0d awvalid=%b required 0", t, awvalid);
        end
        awready = 1'($urandom_range(0, 1));
      end
      // W channel
      checks++;
      if (!w_done) begin
        if (wvalid !== 1'b1 || wdata !== data || wstrb !== exp_strb(strb)) begin
          errors++;
          $display("FAIL w_hold: t=%0d wvalid=%b wdata=%h wstrb=%h required 1/%h/%h",
                   t, wvalid, wdata, wstrb, data, exp_strb(strb));
        end
        w_hi++;
        if (w_wait >= w_dly) begin wready = 1'b1; w_pend = 1; end
        else begin wready = 1'b0; w_wait++; end
      end else begin
        if (wvalid !== 1'b0) begin
          errors++;
          $display("FAIL w_drop: t=%0d wvalid=%b required 0", t, wvalid);
        end
        wready = 1'($urandom_range(0, 1));
      end
      // B channel
      checks++;
      if (aw_done && w_done) begin
        if (bready !== 1'b1) begin
          errors++;
          $display("FAIL bready_high: t=%0d bready=%b required 1", t, bready);
        end
        if (t_bready < 0) t_bready = t;
        if (do_reset) begin
          areset = 1'b1;
          @(negedge aclock);
          checks++;
          if ({awvalid, wvalid, bready, resp_valid, req_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid: aw/w/b/resp_valid/req_ready=%b required 00000",
                     {awvalid, wvalid, bready, resp_valid, req_ready});
          end
          areset = 1'b0;
          @(negedge aclock);
          checks++;
          if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
          end
          return;
        end
        if (!do_timeout && b_wait == b_dly) begin
          bvalid = 1'b1; bresp = br; b_pend = 1;
        end else begin
          bvalid = 1'b0; bresp = 2'($urandom); b_wait++;
        end
      end else begin
        if (bready !== 1'b0) begin
          errors++;
          $display("FAIL bready_early: t=%0d bready=%b required 0", t, bready);
        end
        bvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bresp  = 2'($urandom);
      end
    end
    checks++;
    if (!resp_seen) begin
      errors++;
      $display("FAIL resp_bound: no completion within 200 cycles, resp_valid=%b required 1", resp_valid);
      return;
    end
    checks++;
    if (aw_hi != aw_dly + 1 || w_hi != w_dly + 1) begin
      errors++;
      $display("FAIL valid_len: aw=%0d w=%0d cycles required %0d/%0d", aw_hi, w_hi, aw_dly + 1, w_dly + 1);
    end
    exp_to   = do_timeout;
    exp_code = do_timeout ? 2'b11 : br;
    exp_err  = do_timeout || (br != 2'b00);
    for (int k = 0; k <= rr_dly; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_code !== exp_code ||
          resp_timeout !== exp_to || req_ready !== 1'b0 || bready !== 1'b0) begin
        errors++;
        $display("FAIL resp_fields: k=%0d valid/err/code/to/req_ready/bready=%b/%b/%0d/%b/%b/%b required 1/%b/%0d/%b/0/0",
                 k, resp_valid, resp_err, resp_code, resp_timeout, req_ready, bready, exp_err, exp_code, exp_to);
      end
      resp_ready = (k == rr_dly);
      req_valid  = (k < rr_dly);
      @(negedge aclock);
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== !do_timeout || bready !== do_timeout) begin
      errors++;
      $display("FAIL after_resp: resp_valid=%b req_ready=%b bready=%b required 0/%b/%b",
               resp_valid, req_ready, bready, !do_timeout, do_timeout);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge aclock);
    checks++;
    if ({awvalid, wvalid, bready, resp_valid, resp_err, resp_code, resp_timeout, req_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b required 0", {awvalid, wvalid, bready, resp_valid,
               resp_err, resp_code, resp_timeout, req_ready});
    end
    areset = 1'b0;
    @(negedge aclock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_basic();
    run_txn(32'ha00003f8, 32'h00000041, 8'h01, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    run_txn(32'h10000004, 32'hdeadbeef, 8'hff, 0, 0, 0, 2'b01, 0, 0, 0, 0);
  endtask

  task automatic test_aw_stall();
    run_txn(32'h20000010, 32'h12345678, 8'h0f, 3, 0, 0, 2'b00, 0, 0, 0, 0);
    run_txn(32'h20000014, 32'h9abcdef0, 8'h03, 0, 2, 1, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_slverr();
    run_txn(32'h30000000, 32'h00000055, 8'h0c, 0, 0, 0, 2'b10, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    run_txn(32'h40000000, 32'h0000aaaa, 8'h01, 1, 0, 0, 2'b00, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bready !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold: k=%0d bready=%b req_ready=%b resp_valid=%b required 1/0/0",
                 k, bready, req_ready, resp_valid);
      end
      bvalid = (k == 4);
      bresp  = 2'b00;
      @(negedge aclock);
    end
    bvalid = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || bready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: req_ready=%b bready=%b resp_valid=%b required 1/0/0",
               req_ready, bready, resp_valid);
    end
    run_txn(32'h40000004, 32'h0000bbbb, 8'h02, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_resp_hold();
    run_txn(32'h50000000, 32'hcafef00d, 8'hf0, 0, 0, 2, 2'b11, 5, 0, 0, 0);
  endtask

  task automatic test_reset_wait_b();
    run_txn(32'h60000000, 32'h11112222, 8'h05, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    run_txn(32'h60000004, 32'h33334444, 8'h0a, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_txn($urandom, $urandom, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 5), 2'($urandom), $urandom_range(0, 2), 0, 0, 1);
    end
  endtask

  initial begin
    areset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
    resp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    test_reset();
    test_basic();
    test_aw_stall();
    test_slverr();
    test_timeout();
    test_resp_hold();
    test_reset_wait_b();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
